// File: rtl/bit_recovery_pkg.sv
// Shared types and default timing constants for the bit_recovery front end.
// The testbench bit driver uses the same constants.
package bit_recovery_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } state_t;

  localparam int BIT_CYCLES_DEF    = 64;
  localparam int FILTER_CYCLES_DEF = 3;
  localparam int IDLE_BITS_DEF     = 32;
  localparam int BIT_COUNT_W       = 8;

endpackage

// File: rtl/bit_recovery_input_filter.sv
// Two-flop synchronizer plus debounce filter for the raw receiver line.
// Produces the filtered level and a one-cycle edge flag when it changes.
module bit_recovery_input_filter
  import bit_recovery_pkg::*;
#(
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rf_in,
  output logic level,
  output logic level_edge
);

  localparam int FCW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam logic [FCW-1:0] DEB_LAST = FCW'(FILTER_CYCLES - 1);

  logic           sync_p0;
  logic           sync_p1;
  logic           level_q;
  logic           level_d;
  logic [FCW-1:0] deb_cnt;

  // Synchronizer stages, then the debounce decision on the settled sample
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level_q <= 1'b0;
      level_d <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_p0 <= rf_in;
      sync_p1 <= sync_p0;
      level_d <= level_q;
      if (sync_p1 != level_q) begin
        if (deb_cnt == DEB_LAST) begin
          level_q <= sync_p1;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign level      = level_q;
  assign level_edge = level_q ^ level_d;

endmodule

// File: rtl/bit_recovery.sv
// NRZ bit recovery: re-phases on every filtered data edge, strobes one bit per
// period at mid-bit, and brackets each burst with frame_start/frame_end pulses.
module bit_recovery
  import bit_recovery_pkg::*;
#(
  parameter int BIT_CYCLES    = BIT_CYCLES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int IDLE_BITS     = IDLE_BITS_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   rf_in,
  output logic                   serial_data,
  output logic                   serial_clock,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   active,
  output logic [BIT_COUNT_W-1:0] bit_count,
  output logic                   glitch_error
);

  localparam int PW = $clog2(BIT_CYCLES);
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(BIT_CYCLES / 2);
  localparam logic [PW-1:0] PH_Q1   = PW'(BIT_CYCLES / 4);
  localparam logic [PW-1:0] PH_Q3   = PW'((3 * BIT_CYCLES) / 4);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);

  function automatic logic [BIT_COUNT_W-1:0] sat_inc(input logic [BIT_COUNT_W-1:0] v);
    return (v == {BIT_COUNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic level;
  logic level_edge;

  bit_recovery_input_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_input_filter (
    .clock      (clock),
    .reset_n    (reset_n),
    .rf_in      (rf_in),
    .level      (level),
    .level_edge (level_edge)
  );

  state_t                 state_q;
  state_t                 state_nx;
  logic [PW-1:0]          phase_q;
  logic [IW-1:0]          idle_q;
  logic                   done_q;
  logic                   serial_data_q;
  logic                   serial_clock_q;
  logic                   frame_start_q;
  logic                   frame_end_q;
  logic [BIT_COUNT_W-1:0] bit_count_q;
  logic                   glitch_q;

  logic start_evt;
  logic end_evt;
  logic in_rx;
  logic sample;
  logic zero_hit;
  logic mid_edge;

  // An edge on the sampling phase wins: no strobe, only resync.
  assign sample   = in_rx && !done_q && !level_edge && (phase_q == PH_HALF);
  assign zero_hit = sample && !level && (idle_q == IDLE_LAST);
  assign mid_edge = in_rx && level_edge && (phase_q >= PH_Q1) && (phase_q < PH_Q3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (level_edge && level) state_nx = RECEIVE;
      RECEIVE: if (done_q)              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    active    = 1'b0;
    in_rx     = 1'b0;
    start_evt = 1'b0;
    end_evt   = 1'b0;
    case (state_q)
      IDLE:    start_evt = level_edge && level;
      RECEIVE: begin
        active  = 1'b1;
        in_rx   = 1'b1;
        end_evt = done_q;
      end
      default: ;
    endcase
  end

  // Phase, idle and bit bookkeeping; done_q delays frame_end past the last strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q        <= '0;
      idle_q         <= '0;
      done_q         <= 1'b0;
      serial_data_q  <= 1'b0;
      serial_clock_q <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      bit_count_q    <= '0;
      glitch_q       <= 1'b0;
    end else begin
      frame_start_q  <= start_evt;
      frame_end_q    <= end_evt;
      serial_clock_q <= sample;
      if (sample) serial_data_q <= level;
      if (start_evt) begin
        phase_q     <= '0;
        idle_q      <= '0;
        done_q      <= 1'b0;
        bit_count_q <= '0;
        glitch_q    <= 1'b0;
      end else if (in_rx) begin
        if (level_edge || (phase_q == PH_LAST)) phase_q <= '0;
        else                                    phase_q <= phase_q + 1'b1;
        if (level_edge)  idle_q <= '0;
        else if (sample) idle_q <= level ? '0 : idle_q + 1'b1;
        if (sample)   bit_count_q <= sat_inc(bit_count_q);
        if (mid_edge) glitch_q    <= 1'b1;
        done_q <= zero_hit;
      end
    end
  end

  assign serial_data  = serial_data_q;
  assign serial_clock = serial_clock_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign bit_count    = bit_count_q;
  assign glitch_error = glitch_q;

endmodule

// File: tb/tb_bit_recovery.sv
// Directed/randomized bench for bit_recovery: random bursts with a preamble are
// compared against the ideal bit stream and frame bookkeeping derived from them.
module tb_bit_recovery;
  import bit_recovery_pkg::*;

  localparam int PERIOD = 10;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rf_in;
  logic       serial_data;
  logic       serial_clock;
  logic       frame_start;
  logic       frame_end;
  logic       active;
  logic [7:0] bit_count;
  logic       glitch_error;

  bit_recovery dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rf_in        (rf_in),
    .serial_data  (serial_data),
    .serial_clock (serial_clock),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .active       (active),
    .bit_count    (bit_count),
    .glitch_error (glitch_error)
  );

  always #(PERIOD / 2) clock = ~clock;

  int  n_assert = 0;
  int  n_fail   = 0;
  bit  vec[$];
  bit  cap[$];
  int  fs_cnt = 0, fe_cnt = 0, sc_cnt = 0, overlap = 0;
  longint last_sc_t = 0, fe_t = 0;

  // Passive monitor: collects strobed bits per frame and counts pulses.
  always @(negedge clock) begin
    if (frame_start) begin
      cap.delete();
      fs_cnt++;
    end
    if (serial_clock) begin
      cap.push_back(serial_data);
      sc_cnt++;
      last_sc_t = $time;
    end
    if (frame_end) begin
      fe_cnt++;
      fe_t = $time;
    end
    if ((int'(frame_start) + int'(serial_clock) + int'(frame_end)) > 1) overlap++;
  end

  task automatic chk(input int obs, input int exp, input string tag);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_level(input bit v, input int n);
    rf_in = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Preamble 0xAAAAAAAA, random body with runs capped at 14, final bit 1.
  task automatic gen_vec(input int n);
    bit last;
    int run;
    vec.delete();
    for (int i = 0; i < 32; i++) vec.push_back((i % 2) == 0);
    last = 1'b0;
    run  = 1;
    for (int i = 32; i < n - 1; i++) begin
      bit b;
      b = bit'($urandom_range(0, 1));
      if (run >= 13 && b == last) b = ~last;
      run  = (b == last) ? run + 1 : 1;
      last = b;
      vec.push_back(b);
    end
    vec.push_back(1'b1);
  endtask

  task automatic wait_fe(input int fe0, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (fe_cnt != fe0) break;
      @(posedge clock);
      #1;
    end
  endtask

  function automatic int bits_mismatch(input int n);
    int m = 0;
    for (int i = 0; i < n; i++)
      if (i >= cap.size() || cap[i] !== vec[i]) m++;
    return m;
  endfunction

  task automatic run_clean(input int n, input int cyc, input string tag);
    int fs0, fe0, exp_total;
    fs0 = fs_cnt;
    fe0 = fe_cnt;
    gen_vec(n);
    for (int i = 0; i < n; i++) drive_level(vec[i], cyc);
    rf_in = 1'b0;
    wait_fe(fe0, (IDLE_BITS_DEF + 6) * cyc);
    exp_total = n + IDLE_BITS_DEF;
    chk(fe_cnt - fe0, 1, {tag, "_frame_end_cnt"});
    chk(fs_cnt - fs0, 1, {tag, "_frame_start_cnt"});
    chk(bits_mismatch(n), 0, {tag, "_bit_errors"});
    chk(cap.size(), exp_total, {tag, "_strobes"});
    chk(int'(bit_count), (exp_total > 255) ? 255 : exp_total, {tag, "_bit_count"});
    chk(int'(glitch_error), 0, {tag, "_glitch"});
    chk(int'(fe_t - last_sc_t), PERIOD, {tag, "_end_after_strobe"});
    chk(int'(active), 0, {tag, "_active_after"});
    chk(overlap, 0, {tag, "_pulse_overlap"});
  endtask

  initial begin
    int fs0, fe0;
    reset_n = 1'b0;
    rf_in   = 1'b0;

    // Reset held with the line toggling
    repeat (20) begin
      #3 rf_in = ~rf_in;
    end
    #1;
    chk(int'({serial_data, serial_clock, frame_start, frame_end, active, glitch_error, bit_count}),
        0, "reset_outputs");
    @(posedge clock);
    #1;
    rf_in   = 1'b0;
    reset_n = 1'b1;
    drive_level(1'b0, 1000);
    chk(sc_cnt, 0, "idle_no_strobes");
    chk(fs_cnt, 0, "idle_no_frame_start");
    chk(int'(active), 0, "idle_active");

    // Clean and drifted frames
    run_clean(192, BIT_CYCLES_DEF, "clean64");
    drive_level(1'b0, 100);
    run_clean(192, BIT_CYCLES_DEF + 1, "drift65");
    drive_level(1'b0, 100);
    run_clean(192, BIT_CYCLES_DEF - 1, "drift63");
    drive_level(1'b0, 100);

    // Short pulse in idle must not pass the filter
    fs0 = fs_cnt;
    drive_level(1'b1, 2);
    drive_level(1'b0, 50);
    chk(fs_cnt - fs0, 0, "pulse_no_frame_start");
    chk(int'(active), 0, "pulse_active");
    chk(int'(dut.u_input_filter.level), 0, "pulse_level");

    // Mid-bit inversion in bit 40 of a 64-bit frame
    fe0 = fe_cnt;
    gen_vec(64);
    for (int i = 0; i < 64; i++) begin
      if (i == 40) begin
        drive_level(vec[i], 32);
        drive_level(~vec[i], 5);
        drive_level(vec[i], BIT_CYCLES_DEF - 37);
      end else begin
        drive_level(vec[i], BIT_CYCLES_DEF);
      end
    end
    rf_in = 1'b0;
    wait_fe(fe0, (IDLE_BITS_DEF + 12) * BIT_CYCLES_DEF);
    chk(fe_cnt - fe0, 1, "glitch_frame_end");
    chk(int'(glitch_error), 1, "glitch_set");
    drive_level(1'b0, 200);
    chk(int'(glitch_error), 1, "glitch_sticky");

    // Next frame clears glitch, then async reset after 100 bits
    fs0 = fs_cnt;
    fe0 = fe_cnt;
    gen_vec(150);
    for (int i = 0; i < 100; i++) drive_level(vec[i], BIT_CYCLES_DEF);
    chk(fs_cnt - fs0, 1, "rst_frame_start");
    chk(int'(glitch_error), 0, "glitch_cleared");
    chk(int'(bit_count), 100, "rst_pre_bit_count");
    chk(bits_mismatch(100), 0, "rst_pre_bits");
    chk(int'(active), 1, "rst_pre_active");
    #3;
    reset_n = 1'b0;
    rf_in   = 1'b0;
    #1;
    chk(int'({serial_data, serial_clock, frame_start, frame_end, active, glitch_error, bit_count}),
        0, "async_reset_outputs");
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive_level(1'b0, 50);
    chk(fe_cnt - fe0, 0, "rst_no_frame_end");
    chk(int'(active), 0, "rst_active");

    // Long frame after reset: data from bit 0, bit_count saturates
    run_clean(240, BIT_CYCLES_DEF, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
